// File: rtl/sysid_pkg.sv
// Address map, CAPS bit layout and byte-merge helper for the system-ID register block.
package sysid_pkg;

  typedef logic [3:0] addr_t;

  localparam addr_t ADDR_ID        = 4'd0;
  localparam addr_t ADDR_TIMESTAMP = 4'd1;
  localparam addr_t ADDR_CLK_FREQ  = 4'd2;
  localparam addr_t ADDR_CAPS      = 4'd3;
  localparam addr_t ADDR_UPTIME_LO = 4'd4;
  localparam addr_t ADDR_UPTIME_HI = 4'd5;
  localparam addr_t ADDR_SCRATCH0  = 4'd8;

  localparam int CAPS_UPTIME_BIT   = 0;
  localparam int CAPS_NSCRATCH_LSB = 4;
  localparam int CAPS_NSCRATCH_MSB = 6;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sysid_uptime.sv
// 64-bit free-running uptime counter with a HI shadow latched on every LO read.
// Only instantiated when SYSID_UPTIME_EN is defined.
module sysid_uptime (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        clear_i,
  input  logic        latch_i,
  output logic [31:0] count_lo_o,
  output logic [31:0] shadow_o
);

  logic [63:0] count_q, count_d;
  logic [31:0] shadow_q, shadow_d;

  // The shadow captures the pre-clear HI so a LO read that coincides with a clear stays coherent.
  always_comb begin
    count_d  = clear_i ? 64'd0 : count_q + 64'd1;
    shadow_d = latch_i ? count_q[63:32] : shadow_q;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q  <= '0;
      shadow_q <= '0;
    end else begin
      count_q  <= count_d;
      shadow_q <= shadow_d;
    end
  end

  assign count_lo_o = count_q[31:0];
  assign shadow_o   = shadow_q;

endmodule

// File: rtl/sysid_regs.sv
// Avalon-MM system-ID register block: ID, build timestamp, clock rate, capabilities, scratch.
// Define SYSID_UPTIME_EN to add the 64-bit uptime counter at addresses 4/5.
module sysid_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE    = 32'h5C93_A092,
  parameter logic [31:0] TIMESTAMP   = 32'd0,
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned NUM_SCRATCH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

`ifdef SYSID_UPTIME_EN
  localparam logic CAPS_UPTIME = 1'b1;
`else
  localparam logic CAPS_UPTIME = 1'b0;
`endif

  localparam logic [31:0] CAPS_VALUE =
    (32'(CAPS_UPTIME) << CAPS_UPTIME_BIT) |
    ((32'(NUM_SCRATCH) << CAPS_NSCRATCH_LSB) & (32'h7 << CAPS_NSCRATCH_LSB)) |
    (32'(0) << CAPS_NSCRATCH_MSB);

  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [31:0] scratch_d [NUM_SCRATCH];
  logic [31:0] readdata_q, readdata_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_mux;
  logic        scratch_hit;
  logic [1:0]  scratch_idx;
  logic [3:0]  scratch_off;

  assign scratch_off = address - ADDR_SCRATCH0;
  assign scratch_idx = scratch_off[1:0];
  assign scratch_hit = (address >= ADDR_SCRATCH0) && (32'(scratch_off) < NUM_SCRATCH);

`ifdef SYSID_UPTIME_EN
  logic [31:0] uptime_lo;
  logic [31:0] uptime_shadow;

  sysid_uptime u_uptime (
    .clock_i    (clock),
    .reset_n_i  (reset_n),
    .clear_i    (write && (address == ADDR_UPTIME_LO) && (byteenable != 4'b0000)),
    .latch_i    (read && (address == ADDR_UPTIME_LO)),
    .count_lo_o (uptime_lo),
    .shadow_o   (uptime_shadow)
  );
`endif

  always_comb begin
    rdata_mux = '0;
    case (address)
      ADDR_ID:        rdata_mux = ID_VALUE;
      ADDR_TIMESTAMP: rdata_mux = TIMESTAMP;
      ADDR_CLK_FREQ:  rdata_mux = 32'(CLK_FREQ_HZ);
      ADDR_CAPS:      rdata_mux = CAPS_VALUE;
`ifdef SYSID_UPTIME_EN
      ADDR_UPTIME_LO: rdata_mux = uptime_lo;
      ADDR_UPTIME_HI: rdata_mux = uptime_shadow;
`else
      ADDR_UPTIME_LO, ADDR_UPTIME_HI: rdata_mux = '0;
`endif
      default: begin
        for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
          if (scratch_hit && (scratch_idx == 2'(i))) rdata_mux = scratch_q[i];
        end
      end
    endcase
  end

  // Response registers sample the pre-write state, so a read paired with a write returns old data.
  always_comb begin
    rvalid_d   = read;
    readdata_d = read ? rdata_mux : readdata_q;
    for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
      scratch_d[i] = scratch_q[i];
      if (write && scratch_hit && (scratch_idx == 2'(i))) begin
        scratch_d[i] = merge_bytes(scratch_q[i], writedata, byteenable);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
      for (int i = 0; i < int'(NUM_SCRATCH); i++) scratch_q[i] <= '0;
    end else begin
      readdata_q <= readdata_d;
      rvalid_q   <= rvalid_d;
      for (int i = 0; i < int'(NUM_SCRATCH); i++) scratch_q[i] <= scratch_d[i];
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: doc/sysid_regs.md
SYSID_REGS -- requirements
Module: sysid_regs

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h5C93_A092, meaning system ID word.
REQ-002 SHALL have parameter TIMESTAMP, default 32'd0, meaning build timestamp in Unix seconds.
REQ-003 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, meaning the clock frequency reported to software.
REQ-004 SHALL have parameter NUM_SCRATCH, default 2, legal 1..4, meaning the number of R/W scratch words.
REQ-005 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port address, input, 4, Avalon-MM word address.
REQ-008 SHALL have port read, input, 1, read strobe.
REQ-009 SHALL have port write, input, 1, write strobe.
REQ-010 SHALL have port writedata, input, 32, write data.
REQ-011 SHALL have port byteenable, input, 4, per-byte write enables.
REQ-012 SHALL have port readdata, output, 32, registered read data.
REQ-013 SHALL have port readdatavalid, output, 1, one-cycle read-response strobe.

Function
REQ-014 Register map SHALL be:
- 0 ID (RO)
- 1 TIMESTAMP (RO)
- 2 CLK_FREQ_HZ (RO)
- 3 CAPS (RO): bit0 uptime present, bits[6:4] NUM_SCRATCH, rest 0
- 4 UPTIME_LO
- 5 UPTIME_HI
- 8..8+NUM_SCRATCH-1 SCRATCH (R/W)
- all other addresses read 0; writes to them are ignored.
REQ-015 Read latency SHALL be fixed at 1: read sampled in cycle N -> readdatavalid=1 and readdata valid in cycle N+1; back-to-back reads SHALL be sustained at one response per cycle.
REQ-016 readdatavalid SHALL be 0 in any cycle not following a read; readdata SHALL hold its last value when readdatavalid=0.
REQ-017 Writes SHALL complete in the sampling cycle with no wait states; SCRATCH SHALL update only the bytes whose byteenable bit is 1.
REQ-018 Writes to RO addresses 0..3 and 5 SHALL have no effect.
REQ-019 Uptime counter SHALL be 64-bit, increment by 1 every clock, and wrap from 2^64-1 to 0.
REQ-020 Read of UPTIME_LO SHALL return counter[31:0] as sampled in the read cycle, and in that same cycle SHALL latch counter[63:32] into a HI shadow.
REQ-021 Read of UPTIME_HI SHALL return the HI shadow, never the live counter.
REQ-022 Write to UPTIME_LO with any data and byteenable != 0 SHALL clear the counter to 0 on the next edge; the HI shadow SHALL be unaffected.
REQ-023 If read and write are asserted together, the write SHALL take effect and readdata SHALL return the pre-write value.
REQ-024 A simultaneous read and clear of UPTIME_LO SHALL return the pre-clear value and latch the pre-clear HI.

Reset
REQ-025 Asserting reset_n=0 SHALL immediately clear readdata, readdatavalid, the uptime counter, the HI shadow and all SCRATCH words to 0, including mid-read, where the pending readdatavalid is dropped.
REQ-026 After reset_n deasserts, the counter SHALL read 0 or more on the first access, and the first response SHALL have correct 1-cycle latency.

Configuration
REQ-027 Macro SYSID_UPTIME_EN SHALL control the uptime feature:
- defined: uptime counter and HI shadow present; CAPS bit0=1.
- undefined: no counter or shadow flops; addresses 4 and 5 read 0, writes ignored; CAPS bit0=0; all other behaviour unchanged.

Structure
REQ-028 Package sysid_pkg SHALL hold:
- address constants ADDR_ID..ADDR_SCRATCH0
- CAPS bit-position constants
- the 4-bit address typedef.
REQ-029 Counter and shadow SHALL live in sub-module sysid_uptime, instantiated only under SYSID_UPTIME_EN.

Verification
REQ-030 Read each of addresses 0,1,2,3 after reset -> 32'h5C93A092, 0, 50000000, 32'h21 (macro on) one cycle later, each with readdatavalid=1.
REQ-031 Write 32'hDEADBEEF with byteenable 4'b0101 to address 8, then read -> 32'h00AD00EF; read address 10 with NUM_SCRATCH=2 -> 0.
REQ-032 Force counter to 64'h0000_0001_FFFF_FFFF, read address 4 then address 5 three cycles later -> LO 32'hFFFFFFFF, HI 32'h1, not 32'h2.
REQ-033 Force counter to all-ones -> next cycle counter reads 0 and HI shadow latches 0 on the next LO read.
REQ-034 Read and write of address 4 in the same cycle at counter=100 -> readdata 100; a LO read 5 cycles later returns 4 or 5 per the write-edge timing and stays below 10.
REQ-035 Pulse reset_n low between a read and its response -> readdatavalid stays 0 and readdata becomes 0 asynchronously; repeat with the macro undefined -> address 4 reads 0 and CAPS reads 32'h20.
